// File: rtl/crypto_stream_rx.sv
// crypto_stream_rx: keystream-LFSR stream decryptor with plaintext output FIFO and frame tracking.
// Optional CRYPTO_RX_CHECKSUM_EN adds a per-frame XOR checksum check on chk_err.
module crypto_stream_rx #(
  parameter logic [7:0] SEED       = 8'hAC,
  parameter int         FIFO_DEPTH = 4,
  parameter int         MAX_FRAME  = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       seed_load,
  input  logic [7:0] seed_in,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic [7:0] s_data,
  input  logic       s_last,
  output logic       m_valid,
  input  logic       m_ready,
  output logic [7:0] m_data,
  output logic       m_last,
  output logic       frame_active,
  output logic       len_err
`ifdef CRYPTO_RX_CHECKSUM_EN
  ,
  output logic       chk_err
`endif
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [63:0] INV_TAB = 64'h97B2_FDEC_5031_A684;
  typedef enum logic {IDLE, FRAME} state_t;
  state_t state, state_nxt;
  logic [7:0] lfsr, byte_cnt, t, p;
  logic [8:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic accept, pop, cnt_hit, frame_end, ovf;
  assign t = {INV_TAB[{s_data[7:4], 2'b00} +: 4], INV_TAB[{s_data[3:0], 2'b00} +: 4]};
  assign p = {t[0], t[7:1]} ^ lfsr;
  assign s_ready = (count != (AW+1)'(FIFO_DEPTH)) & !seed_load;
  assign accept = s_valid & s_ready;
  assign m_valid = count != '0;
  assign pop = m_valid & m_ready;
  assign cnt_hit = byte_cnt == 8'(MAX_FRAME - 1);
  assign ovf = accept & !s_last & cnt_hit;
  assign frame_end = accept & (s_last | cnt_hit);
  assign m_data = m_valid ? mem[rd_ptr][7:0] : 8'h00;
  assign m_last = m_valid & mem[rd_ptr][8];
  assign frame_active = state == FRAME;
  always_comb begin
    state_nxt = (seed_load | frame_end) ? IDLE : accept ? FRAME : state;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      lfsr     <= SEED;
      byte_cnt <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      len_err  <= 1'b0;
    end else begin
      state   <= state_nxt;
      len_err <= ovf;
      if (seed_load) begin
        lfsr     <= |seed_in ? seed_in : SEED;
        byte_cnt <= '0;
      end else if (frame_end) begin
        lfsr     <= SEED;
        byte_cnt <= '0;
      end else if (accept) begin
        lfsr     <= {lfsr[6:0], ^lfsr[7:3]};
        byte_cnt <= byte_cnt + 8'd1;
      end
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(accept) - (AW+1)'(pop);
    end
  end
  // Storage carries no reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= {s_last | ovf, p};
  end
`ifdef CRYPTO_RX_CHECKSUM_EN
  logic [7:0] xacc;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xacc    <= '0;
      chk_err <= 1'b0;
    end else begin
      chk_err <= accept & s_last & (p != xacc);
      if (seed_load | frame_end) xacc <= '0;
      else if (accept) xacc <= xacc ^ p;
    end
  end
`endif
endmodule

// File: tb/tb_crypto_stream_rx.sv
// tb_crypto_stream_rx: scoreboard bench with a behavioural cipher/FIFO model for crypto_stream_rx.
module tb_crypto_stream_rx;
  localparam int DEPTH = 4;
  localparam int MAXF = 16;
  localparam int SEED = 8'hAC;
  logic clk = 0, rst_n = 0, seed_load = 0, s_valid = 0, s_last = 0, m_ready = 0;
  logic [7:0] seed_in = 0, s_data = 0;
  logic s_ready, m_valid, m_last, frame_active, len_err;
  logic [7:0] m_data;
`ifdef CRYPTO_RX_CHECKSUM_EN
  logic chk_err;
`endif
  int checks = 0, errors = 0;
  logic [8:0] q[$];
  int lfsr_m = SEED, cnt_m = 0, xacc_m = 0, p_m;
  bit exp_len = 0, exp_chk = 0, acc_m, ovf_m, lst_m;
  int inv_tab[16] = '{4, 8, 6, 10, 1, 3, 0, 5, 12, 14, 13, 15, 2, 11, 7, 9};

  crypto_stream_rx dut (
    .clk(clk), .rst_n(rst_n), .seed_load(seed_load), .seed_in(seed_in),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .frame_active(frame_active), .len_err(len_err)
`ifdef CRYPTO_RX_CHECKSUM_EN
    , .chk_err(chk_err)
`endif
  );

  always #5 clk = ~clk;

  function automatic int dec(input int c);
    int tt;
    tt = inv_tab[(c / 16) % 16] * 16 + inv_tab[c % 16];
    return (tt / 2) + (tt % 2) * 128;
  endfunction

  function automatic int step(input int x);
    return ((x * 2) % 256) + ($countones((x / 8) % 32) % 2);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic l);
    logic ok;
    s_valid = 1; s_data = d; s_last = l;
    for (int i = 0; ; i++) begin
      @(negedge clk);
      ok = s_ready;
      @(posedge clk);
      #1;
      if (ok) break;
      if (i > 200) begin
        checks++; errors++;
        $display("FAIL send_timeout: byte %0h never accepted", d);
        break;
      end
    end
    s_valid = 0; s_last = 0;
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      q.delete(); lfsr_m = SEED; cnt_m = 0; xacc_m = 0; exp_len = 0; exp_chk = 0;
    end else begin
      acc_m = s_valid && q.size() < DEPTH && !seed_load;
      exp_len = 0; exp_chk = 0;
      if (m_ready && q.size() > 0) void'(q.pop_front());
      if (seed_load) begin
        lfsr_m = (seed_in != 0) ? int'(seed_in) : SEED; cnt_m = 0; xacc_m = 0;
      end else if (acc_m) begin
        p_m = dec(int'(s_data)) ^ lfsr_m;
        ovf_m = !s_last && cnt_m + 1 == MAXF;
        lst_m = s_last || ovf_m;
        exp_len = ovf_m;
        exp_chk = s_last && p_m != xacc_m;
        q.push_back({lst_m, 8'(p_m)});
        if (lst_m) begin
          lfsr_m = SEED; cnt_m = 0; xacc_m = 0;
        end else begin
          lfsr_m = step(lfsr_m); cnt_m++; xacc_m = xacc_m ^ p_m;
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    chk("s_ready", int'(s_ready), int'(q.size() < DEPTH && !seed_load));
    chk("m_valid", int'(m_valid), int'(q.size() != 0));
    chk("frame_active", int'(frame_active), int'(cnt_m != 0));
    chk("len_err", int'(len_err), int'(exp_len));
`ifdef CRYPTO_RX_CHECKSUM_EN
    chk("chk_err", int'(chk_err), int'(exp_chk));
`endif
    if (q.size() != 0 && m_valid) begin
      chk("m_data", int'(m_data), int'(q[0][7:0]));
      chk("m_last", int'(m_last), int'(q[0][8]));
    end
  end

  initial begin
    tick(3);
    rst_n = 1;
    tick(1);
    m_ready = 1;
    send(8'h7F, 0);
    send(8'hDC, 1);
    tick(3);
    m_ready = 0;
    fork
      begin
        for (int i = 0; i < 5; i++) send(8'($urandom), i == 4);
      end
      begin
        tick(10);
        m_ready = 1;
        tick(1);
        m_ready = 0;
      end
    join
    m_ready = 1;
    tick(8);
    for (int i = 0; i < 16; i++) send(8'($urandom), 0);
    send(8'h7F, 1);
    tick(4);
    for (int i = 0; i < 3; i++) send(8'($urandom), 0);
    seed_load = 1; seed_in = 8'h00; s_valid = 1; s_data = 8'($urandom);
    tick(1);
    seed_load = 0; s_valid = 0;
    send(8'h7F, 1);
    tick(4);
`ifdef CRYPTO_RX_CHECKSUM_EN
    send(8'h7F, 0); send(8'hDC, 0); send(8'h2E, 1);
    send(8'h7F, 0); send(8'hDC, 0); send(8'h2F, 1);
    tick(4);
`endif
    m_ready = 0;
    send(8'($urandom), 0);
    send(8'($urandom), 0);
    @(posedge clk);
    #3 rst_n = 0;
    #1;
    chk("async_m_valid", int'(m_valid), 0);
    chk("async_frame_active", int'(frame_active), 0);
    tick(1);
    rst_n = 1;
    m_ready = 1;
    send(8'h7F, 1);
    tick(4);
    repeat (400) begin
      s_valid = ($urandom % 4) != 0;
      s_data = 8'($urandom);
      s_last = ($urandom % 6) == 0;
      m_ready = ($urandom % 3) != 0;
      seed_load = ($urandom % 40) == 0;
      seed_in = ($urandom % 2) != 0 ? 8'($urandom) : 8'h00;
      tick(1);
    end
    s_valid = 0; s_last = 0; seed_load = 0; m_ready = 1;
    tick(10);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
